// File: rtl/mul_wb_buffer.sv
// rtl/mul_wb_buffer.sv - multiply writeback completion FIFO toward the ROB write port (optional same-cycle bypass: MUL_WB_BYPASS_EN)
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif
`ifndef INSTR_TYPE_SZ
`define INSTR_TYPE_SZ 4
`endif
`ifndef ROB_ENTRY_WIDTH
`define ROB_ENTRY_WIDTH 5
`endif

module mul_wb_buffer #(
   parameter int WORD_SIZE       = `WORD_SIZE,
   parameter int INSTR_TYPE_SZ   = `INSTR_TYPE_SZ,
   parameter int ROB_ENTRY_WIDTH = `ROB_ENTRY_WIDTH,
   parameter int DEPTH           = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       flush,
   input  logic                       in_valid,
   input  logic [INSTR_TYPE_SZ-1:0]   in_instruction_type,
   input  logic [WORD_SIZE-1:0]       in_pc,
   input  logic [WORD_SIZE-1:0]       in_result,
   input  logic [ROB_ENTRY_WIDTH-1:0] in_rob_id,
   output logic                       stall_out,
   output logic                       wb_valid,
   output logic [INSTR_TYPE_SZ-1:0]   wb_instruction_type,
   output logic [WORD_SIZE-1:0]       wb_pc,
   output logic [WORD_SIZE-1:0]       wb_result,
   output logic [ROB_ENTRY_WIDTH-1:0] wb_rob_id,
   input  logic                       wb_ready,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [INSTR_TYPE_SZ-1:0]   r_type_mem [DEPTH];
   logic [WORD_SIZE-1:0]       r_pc_mem   [DEPTH];
   logic [WORD_SIZE-1:0]       r_res_mem  [DEPTH];
   logic [ROB_ENTRY_WIDTH-1:0] r_rob_mem  [DEPTH];

   logic [PW-1:0] r_wr_ptr;
   logic [PW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;

   logic w_fifo_valid;
   logic w_push;
   logic w_pop;

   // Full/empty come from registered occupancy only, so stall never depends on wb_ready
   assign w_fifo_valid = (r_count != '0);
   assign stall_out    = (r_count == FULL_CNT);
   assign count        = r_count;
   assign w_pop        = w_fifo_valid && wb_ready && !flush;

`ifdef MUL_WB_BYPASS_EN
   // A completion arriving into an empty buffer that the ROB takes immediately skips the FIFO
   assign w_push = in_valid && !stall_out && !flush && !(!w_fifo_valid && wb_ready);
`else
   assign w_push = in_valid && !stall_out && !flush;
`endif

   // Entry storage needs no reset; occupancy alone decides what is valid
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_type_mem[r_wr_ptr] <= in_instruction_type;
         r_pc_mem[r_wr_ptr]   <= in_pc;
         r_res_mem[r_wr_ptr]  <= in_result;
         r_rob_mem[r_wr_ptr]  <= in_rob_id;
      end
   end

   // Pointer and occupancy update; flush wins over push and pop
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Present the head entry, or zeros when empty
   always_comb begin
      wb_valid            = w_fifo_valid;
      wb_instruction_type = '0;
      wb_pc               = '0;
      wb_result           = '0;
      wb_rob_id           = '0;
      if (w_fifo_valid) begin
         wb_instruction_type = r_type_mem[r_rd_ptr];
         wb_pc               = r_pc_mem[r_rd_ptr];
         wb_result           = r_res_mem[r_rd_ptr];
         wb_rob_id           = r_rob_mem[r_rd_ptr];
      end
`ifdef MUL_WB_BYPASS_EN
      else if (in_valid && !flush) begin
         wb_valid            = 1'b1;
         wb_instruction_type = in_instruction_type;
         wb_pc               = in_pc;
         wb_result           = in_result;
         wb_rob_id           = in_rob_id;
      end
`endif
   end

endmodule

// File: tb/tb_mul_wb_buffer.sv
// tb/tb_mul_wb_buffer.sv - directed self-checking bench for mul_wb_buffer
module tb_mul_wb_buffer;

   localparam int W = 32;
   localparam int T = 4;
   localparam int R = 5;
   localparam int D = 4;

   logic         clk;
   logic         reset;
   logic         flush;
   logic         in_valid;
   logic [T-1:0] in_instruction_type;
   logic [W-1:0] in_pc;
   logic [W-1:0] in_result;
   logic [R-1:0] in_rob_id;
   logic         stall_out;
   logic         wb_valid;
   logic [T-1:0] wb_instruction_type;
   logic [W-1:0] wb_pc;
   logic [W-1:0] wb_result;
   logic [R-1:0] wb_rob_id;
   logic         wb_ready;
   logic [2:0]   count;

   int n_tests = 0;
   int n_fail  = 0;

   mul_wb_buffer #(
      .WORD_SIZE(W), .INSTR_TYPE_SZ(T), .ROB_ENTRY_WIDTH(R), .DEPTH(D)
   ) dut (
      .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid),
      .in_instruction_type(in_instruction_type), .in_pc(in_pc),
      .in_result(in_result), .in_rob_id(in_rob_id), .stall_out(stall_out),
      .wb_valid(wb_valid), .wb_instruction_type(wb_instruction_type),
      .wb_pc(wb_pc), .wb_result(wb_result), .wb_rob_id(wb_rob_id),
      .wb_ready(wb_ready), .count(count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [W-1:0] res, input logic [R-1:0] rob);
      in_valid            = v;
      in_result           = res;
      in_rob_id           = rob;
      in_pc               = 32'h1000 + res;
      in_instruction_type = res[3:0];
   endtask

   initial begin
      int sent;
      int recv;
      int cyc;
      logic accepted;
      reset = 1'b0; flush = 1'b0; wb_ready = 1'b0;
      drive(1'b0, '0, '0);
      #2;
      check("rst_valid", wb_valid, 0);
      check("rst_stall", stall_out, 0);
      check("rst_count", count, 0);
      check("rst_result", wb_result, 0);
      tick(); tick();
      reset = 1'b1;

      // first push after reset, one-cycle latency
      in_valid = 1'b1; in_pc = 32'h100; in_result = 32'h2A; in_rob_id = 5'd3; in_instruction_type = 4'd1;
      tick();
      in_valid = 1'b0;
      check("first_valid", wb_valid, 1);
      check("first_result", wb_result, 32'h2A);
      check("first_rob", wb_rob_id, 3);
      check("first_pc", wb_pc, 32'h100);
      check("first_type", wb_instruction_type, 1);
      check("first_count", count, 1);
      wb_ready = 1'b1;
      tick();
      check("drain_count", count, 0);
      check("drain_valid", wb_valid, 0);
      check("drain_result_zero", wb_result, 0);

      // fill and stall
      wb_ready = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         drive(1'b1, W'(i), R'(i));
         tick();
      end
      check("full_count", count, 4);
      check("full_stall", stall_out, 1);
      drive(1'b1, 32'd5, 5'd5);
      tick();
      drive(1'b0, '0, '0);
      check("ignored_count", count, 4);
      check("ignored_head", wb_result, 1);
      wb_ready = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         check("fill_order", wb_result, i);
         check("fill_rob", wb_rob_id, i);
         tick();
      end
      check("fill_end_stall", stall_out, 0);
      check("fill_end_count", count, 0);
      check("fill_end_valid", wb_valid, 0);

      // push and pop together while full
      wb_ready = 1'b0;
      for (int i = 11; i <= 14; i++) begin
         drive(1'b1, W'(i), R'(i));
         tick();
      end
      check("sim_full", stall_out, 1);
      wb_ready = 1'b1;
      drive(1'b1, 32'h55, 5'd21);
      tick();
      check("sim_count1", count, 3);
      check("sim_stall_drop", stall_out, 0);
      check("sim_head1", wb_result, 12);
      tick();
      drive(1'b0, '0, '0);
      check("sim_count2", count, 3);
      check("sim_head2", wb_result, 13);
      tick();
      check("sim_head3", wb_result, 14);
      tick();
      check("sim_held_input", wb_result, 32'h55);
      check("sim_held_rob", wb_rob_id, 21);
      tick();
      check("sim_empty", count, 0);

      // wrap-around with wb_ready toggling every cycle
      sent = 0; recv = 0; cyc = 0;
      while (recv < 10 && cyc < 200) begin
         wb_ready = cyc[0];
         drive(sent < 10, W'(32'h200 + sent), R'(sent));
         #1;
         accepted = in_valid && !stall_out;
         if (wb_valid && wb_ready) begin
            check("wrap_order", wb_result, 32'h200 + recv);
            recv++;
         end
         tick();
         if (accepted) sent++;
         cyc++;
      end
      drive(1'b0, '0, '0);
      wb_ready = 1'b0;
      check("wrap_delivered", recv, 10);
      check("wrap_sent", sent, 10);
      check("wrap_empty", count, 0);

      // flush kills buffered and incoming completions
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, W'(32'h31 + i), R'(i));
         tick();
      end
      check("flush_pre_count", count, 3);
      flush = 1'b1;
      drive(1'b1, 32'h99, 5'd9);
      tick();
      flush = 1'b0;
      drive(1'b0, '0, '0);
      check("flush_count", count, 0);
      check("flush_valid", wb_valid, 0);
      wb_ready = 1'b1;
      tick(); tick();
      check("flush_no_ghost", wb_valid, 0);
      drive(1'b1, 32'h77, 5'd7);
      tick();
      drive(1'b0, '0, '0);
      wb_ready = 1'b0;
      check("post_flush_head", wb_result, 32'h77);
      check("post_flush_count", count, 1);

      // asynchronous reset mid-cycle with two buffered entries
      drive(1'b1, 32'h88, 5'd8);
      tick();
      drive(1'b0, '0, '0);
      check("areset_pre_count", count, 2);
      @(negedge clk);
      #1;
      reset = 1'b0;
      #1;
      check("areset_valid", wb_valid, 0);
      check("areset_count", count, 0);
      check("areset_result", wb_result, 0);
      tick();
      reset = 1'b1;
      tick();
      check("areset_stays_empty", wb_valid, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/mul_wb_buffer.md
# mul_wb_buffer

Writeback-side receiver for the multiply pipeline's final stage. It captures each valid completion (instruction type, PC, result, ROB id) leaving M4 into a small in-order FIFO, then presents the completions one at a time to the ROB write port under a valid/ready handshake. When the FIFO fills, it raises `stall_out` back into the M-stage pipeline registers, so no completion is lost while the ROB port is granted to other units.

## Interface
- `WORD_SIZE`, default `` `WORD_SIZE ``: width of PC and result.
- `INSTR_TYPE_SZ`, default `` `INSTR_TYPE_SZ ``: width of the instruction-type field.
- `ROB_ENTRY_WIDTH`, default `` `ROB_ENTRY_WIDTH ``: width of the ROB id.
- `DEPTH`, default 4: number of FIFO entries; power of two, ≥2.

Ports (name, direction, width, meaning):
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset (0 = reset).
- `flush`  in  1  synchronous kill of all buffered and incoming completions.
- `in_valid`  in  1  M4 output carries a completion.
- `in_instruction_type`  in  INSTR_TYPE_SZ  type of the incoming completion.
- `in_pc`  in  WORD_SIZE  PC of the incoming completion.
- `in_result`  in  WORD_SIZE  result of the incoming completion.
- `in_rob_id`  in  ROB_ENTRY_WIDTH  ROB id of the incoming completion.
- `stall_out`  out  1  back-pressure to the M pipeline; high means the input is not accepted.
- `wb_valid`  out  1  head entry is presented to the ROB.
- `wb_instruction_type`  out  INSTR_TYPE_SZ  head entry's instruction type.
- `wb_pc`  out  WORD_SIZE  head entry's PC.
- `wb_result`  out  WORD_SIZE  head entry's result.
- `wb_rob_id`  out  ROB_ENTRY_WIDTH  head entry's ROB id.
- `wb_ready`  in  1  ROB grants the write port this cycle.
- `count`  out  $clog2(DEPTH)+1  current occupancy.

## Operation
- **Push:** when `in_valid && !stall_out && !flush`, the four input fields are written at `wr_ptr`, and `wr_ptr` increments.
- **Pop:** when `wb_valid && wb_ready && !flush`, `rd_ptr` increments.
- **Push and pop in the same cycle:** both happen and `count` is unchanged. This is legal at any occupancy below DEPTH.
- **Pointers:** `$clog2(DEPTH)` bits wide; they wrap from DEPTH-1 to 0 naturally.
- **Full:** `stall_out = (count == DEPTH)`. It is a registered-state function only; there is no combinational path from `wb_ready`. While full, `in_*` are ignored.
- **Empty:** `wb_valid = 0`, and all `wb_*` data outputs drive 0.
- **Ordering:** strict FIFO. Completions reach the ROB in M4 exit order.
- **Flush:** has priority over push and pop. On the next edge `count = 0`, both pointers = 0, and any input presented that cycle is discarded.
- **Reset:** asserting `reset` low immediately clears `count`, the pointers and `stall_out`, and sets `wb_valid = 0` with `wb_*` = 0. Entry storage does not need clearing. Reset mid-operation drops all entries. The first push is accepted on the first rising edge after `reset` is released.

## Timing
- **Latency:** a completion pushed at edge N appears on `wb_*` with `wb_valid = 1` after edge N, if the FIFO was empty.
- **Occupancy and stall:** `count` and `stall_out` update on the same edge as the push or pop that changes them. A pop at edge N on a full FIFO drops `stall_out` after edge N, and the input can be accepted at edge N+1.
- **Hold under back-pressure:** `wb_*` holds steady while `wb_valid && !wb_ready`.
- **Throughput:** one completion per cycle in steady state, with `wb_ready` held high.

## Configuration
- **`MUL_WB_BYPASS_EN` defined:** when `count == 0` and `in_valid && !flush`, the `in_*` fields drive `wb_*` combinationally and `wb_valid = 1` in the same cycle.
  - If `wb_ready` is also high, the completion is consumed directly and is not written to the FIFO; `count` stays 0.
  - If `wb_ready` is low, it is pushed normally.
- **Not defined:** no bypass; minimum latency is one cycle as stated under Timing.

## Test plan
- **Reset:** hold `reset = 0` → `wb_valid = 0`, `stall_out = 0`, `count = 0`, `wb_result = 0`. Release `reset`, push PC 0x100 / result 0x2A / rob_id 3 → next cycle `wb_valid = 1`, `wb_result = 0x2A`, `wb_rob_id = 3`.
- **Fill and stall:** `wb_ready = 0`, push 4 entries (results 1..4) → `count = 4`, `stall_out = 1`. A fifth push with result 5 is ignored. Raise `wb_ready` for 4 cycles → results 1,2,3,4 in order. Then `stall_out = 0` and `count = 0`.
- **Simultaneous push/pop at full:** full FIFO, `wb_ready = 1`, `in_valid = 1` → the pop completes and the push is rejected at that edge. `stall_out` drops after that edge, and the held input is accepted at the next edge.
- **Wrap-around:** 10 completions with `wb_ready` toggling 1/0 each cycle → all 10 are delivered in order, none duplicated. Pointers wrap twice.
- **Flush:** 3 entries buffered, assert `flush` with `in_valid = 1` → next cycle `count = 0` and `wb_valid = 0`; the flushed input never appears.
- **Async reset:** assert `reset` mid-cycle with 2 entries buffered → `wb_valid` falls before the next clock edge.
